// File: rtl/dm_wb_pkg.sv
// Shared types and constants for the posted-store write buffer.
// The default widths match the top-level parameter defaults.
package dm_wb_pkg;
  localparam int WB_ADDR_W   = 32;
  localparam int WB_DATA_W   = 32;
  localparam int WB_ID_W     = 4;
  localparam int WB_WORD_LSB = 2;

  typedef struct packed {
    logic [WB_ADDR_W-1:0]   addr;
    logic [WB_DATA_W-1:0]   data;
    logic [WB_DATA_W/8-1:0] strb;
    logic [WB_ID_W-1:0]     id;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } wb_state_e;
endpackage

// File: rtl/dm_wb_cam.sv
// Word-granular address compare across all buffer entries.
// Also reports the youngest match, searching backwards from the write pointer.
module dm_wb_cam
  import dm_wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][ADDR_W-1:0] i_entry_addr,
  input  logic [DEPTH-1:0]             i_valid,
  input  logic [ADDR_W-1:0]            i_chk_addr,
  input  logic [PTR_W-1:0]             i_wr_ptr,
  output logic [DEPTH-1:0]             o_match,
  output logic                         o_any,
  output logic [PTR_W-1:0]             o_young_idx
);
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    o_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_match[i] = i_valid[i] &&
        (i_entry_addr[i][ADDR_W-1:WB_WORD_LSB] == i_chk_addr[ADDR_W-1:WB_WORD_LSB]);
    end
  end

  always_comb begin
    o_young_idx = '0;
    w_found     = 1'b0;
    w_idx       = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      w_idx = i_wr_ptr - PTR_W'(k);
      if (!w_found && o_match[w_idx]) begin
        o_young_idx = w_idx;
        w_found     = 1'b1;
      end else begin
        w_found     = w_found;
      end
    end
  end

  assign o_any = |o_match;
endmodule

// File: rtl/dm_write_buffer.sv
// In-order posted-store buffer feeding single-beat writes to Master_Write.
// Store-to-load forwarding is enabled by defining DM_WB_FWD_EN.
module dm_write_buffer
  import dm_wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DATA_W = WB_DATA_W,
  parameter int ID_W   = WB_ID_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_wr_req,
  input  logic [ADDR_W-1:0]   i_wr_addr,
  input  logic [DATA_W-1:0]   i_wr_data,
  input  logic [DATA_W/8-1:0] i_wr_strb,
  input  logic [ID_W-1:0]     i_wr_id,
  output logic                o_wr_stall,
  input  logic                i_rd_chk_req,
  input  logic [ADDR_W-1:0]   i_rd_chk_addr,
  output logic                o_rd_hazard,
  output logic                o_rd_fwd_valid,
  output logic [DATA_W-1:0]   o_rd_fwd_data,
  output logic                o_mw_req,
  output logic [ADDR_W-1:0]   o_mw_addr,
  output logic [DATA_W-1:0]   o_mw_data,
  output logic [DATA_W/8-1:0] o_mw_strb,
  output logic [ID_W-1:0]     o_mw_id,
  input  logic                i_mw_ack,
  input  logic                i_mw_done,
  output logic                o_wb_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t               r_mem [DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;
  wb_state_e               r_state;
  wb_state_e               w_state_nxt;
  logic [CNT_W-1:0]        w_count_nxt;
  logic                    w_full;
  logic                    w_push;
  logic                    w_pop;
  logic [PTR_W-1:0]        w_off;
  logic [DEPTH-1:0]        w_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] w_entry_addr;
  logic [DEPTH-1:0]        w_match;
  logic                    w_any;
  logic [PTR_W-1:0]        w_young_idx;

  assign w_full = (r_count == CNT_W'(DEPTH));
  assign w_push = i_wr_req & ~w_full;
  assign w_pop  = (r_state == WAIT_RESP) & i_mw_done;

  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (r_count != '0) w_state_nxt = ISSUE; else w_state_nxt = IDLE;
      ISSUE:     if (i_mw_ack) w_state_nxt = WAIT_RESP; else w_state_nxt = ISSUE;
      WAIT_RESP: begin
        if (i_mw_done) w_state_nxt = (w_count_nxt != '0) ? ISSUE : IDLE;
        else           w_state_nxt = WAIT_RESP;
      end
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_wr_ptr <= w_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
      r_rd_ptr <= w_pop  ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
    end
  end

  // Entry payload needs no reset: validity comes from count and pointers.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) begin
      r_mem[r_wr_ptr] <= '{addr: i_wr_addr, data: i_wr_data, strb: i_wr_strb, id: i_wr_id};
    end
  end

  always_comb begin
    w_off        = '0;
    w_valid      = '0;
    w_entry_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off           = PTR_W'(i) - r_rd_ptr;
      w_valid[i]      = (CNT_W'(w_off) < r_count);
      w_entry_addr[i] = r_mem[i].addr;
    end
  end

  dm_wb_cam #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .PTR_W(PTR_W)) u_cam (
    .i_entry_addr (w_entry_addr),
    .i_valid      (w_valid),
    .i_chk_addr   (i_rd_chk_addr),
    .i_wr_ptr     (r_wr_ptr),
    .o_match      (w_match),
    .o_any        (w_any),
    .o_young_idx  (w_young_idx)
  );

`ifdef DM_WB_FWD_EN
  logic w_young_full;
  assign w_young_full   = &r_mem[w_young_idx].strb;
  assign o_rd_fwd_valid = i_rd_chk_req & w_any & w_young_full;
  assign o_rd_fwd_data  = o_rd_fwd_valid ? r_mem[w_young_idx].data : '0;
  assign o_rd_hazard    = i_rd_chk_req & w_any & ~w_young_full;
`else
  logic w_unused_young;
  assign w_unused_young = ^w_young_idx;
  assign o_rd_fwd_valid = 1'b0;
  assign o_rd_fwd_data  = '0;
  assign o_rd_hazard    = i_rd_chk_req & w_any;
`endif

  assign o_wr_stall = w_full;
  assign o_wb_empty = (r_count == '0) && (r_state == IDLE);
  assign o_mw_req   = (r_state == ISSUE);
  assign o_mw_addr  = r_mem[r_rd_ptr].addr;
  assign o_mw_data  = r_mem[r_rd_ptr].data;
  assign o_mw_strb  = r_mem[r_rd_ptr].strb;
  assign o_mw_id    = r_mem[r_rd_ptr].id;
endmodule

// File: tb/tb_dm_write_buffer.sv
// Randomized plus directed bench for dm_write_buffer against a queue-based model.
module tb_dm_write_buffer;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  id;
  } st_t;

  logic        clk = 1'b0;
  logic        rst, wr_req, rd_chk_req, mw_ack, mw_done;
  logic [31:0] wr_addr, wr_data, rd_chk_addr;
  logic [3:0]  wr_strb, wr_id;
  logic        wr_stall, rd_hazard, rd_fwd_valid, mw_req, wb_empty;
  logic [31:0] rd_fwd_data, mw_addr, mw_data;
  logic [3:0]  mw_strb, mw_id;

  st_t q[$];
  int  phase;           // 0 nothing issued, 1 presenting head, 2 awaiting response
  int  total = 0;
  int  bad   = 0;

  always #5 clk = ~clk;

  dm_write_buffer dut (
    .i_clk(clk), .i_rst(rst), .i_wr_req(wr_req), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_wr_strb(wr_strb), .i_wr_id(wr_id), .o_wr_stall(wr_stall),
    .i_rd_chk_req(rd_chk_req), .i_rd_chk_addr(rd_chk_addr), .o_rd_hazard(rd_hazard),
    .o_rd_fwd_valid(rd_fwd_valid), .o_rd_fwd_data(rd_fwd_data), .o_mw_req(mw_req),
    .o_mw_addr(mw_addr), .o_mw_data(mw_data), .o_mw_strb(mw_strb), .o_mw_id(mw_id),
    .i_mw_ack(mw_ack), .i_mw_done(mw_done), .o_wb_empty(wb_empty)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit          found = 1'b0;
    logic [3:0]  ys = 4'h0;
    logic [31:0] yd = 32'h0;
    logic        e_hz, e_fv;
    logic [31:0] e_fd;
    for (int k = q.size() - 1; k >= 0; k--) begin
      if (!found && q[k].addr[31:2] == rd_chk_addr[31:2]) begin
        found = 1'b1;
        ys    = q[k].strb;
        yd    = q[k].data;
      end
    end
`ifdef DM_WB_FWD_EN
    e_fv = rd_chk_req && found && (ys == 4'hF);
    e_fd = e_fv ? yd : 32'h0;
    e_hz = rd_chk_req && found && (ys != 4'hF);
`else
    e_fv = 1'b0;
    e_fd = 32'h0;
    e_hz = rd_chk_req && found;
`endif
    check("wr_stall", {31'd0, wr_stall}, {31'd0, q.size() == 4});
    check("wb_empty", {31'd0, wb_empty}, {31'd0, (q.size() == 0) && (phase == 0)});
    check("mw_req", {31'd0, mw_req}, {31'd0, phase == 1});
    check("rd_hazard", {31'd0, rd_hazard}, {31'd0, e_hz});
    check("fwd_valid", {31'd0, rd_fwd_valid}, {31'd0, e_fv});
    check("fwd_data", rd_fwd_data, e_fd);
    if (phase == 1) begin
      check("mw_addr", mw_addr, q[0].addr);
      check("mw_data", mw_data, q[0].data);
      check("mw_strb", {28'd0, mw_strb}, {28'd0, q[0].strb});
      check("mw_id", {28'd0, mw_id}, {28'd0, q[0].id});
    end
  endtask

  task automatic update_model();
    bit pop, push;
    int nph;
    if (rst) begin
      q.delete();
      phase = 0;
    end else begin
      pop  = (phase == 2) && mw_done;
      push = wr_req && (q.size() < 4);
      nph  = phase;
      if (phase == 0)      nph = (q.size() != 0) ? 1 : 0;
      else if (phase == 1) nph = mw_ack ? 2 : 1;
      else if (mw_done)    nph = ((q.size() - int'(pop) + int'(push)) != 0) ? 1 : 0;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back('{addr: wr_addr, data: wr_data, strb: wr_strb, id: wr_id});
      phase = nph;
    end
  endtask

  // One clock: apply inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic ack, input logic done,
                      input logic chk, input logic [31:0] ca, input logic r);
    wr_req = wr; wr_addr = a; wr_data = d; wr_strb = s; wr_id = a[5:2];
    mw_ack = ack; mw_done = done; rd_chk_req = chk; rd_chk_addr = ca; rst = r;
    #2;
    check_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle(input logic ack, input logic done);
    step(1'b0, 32'h0, 32'h0, 4'h0, ack, done, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0; wr_id = '0;
    mw_ack = 1'b0; mw_done = 1'b0; rd_chk_req = 1'b0; rd_chk_addr = '0;
    q.delete();
    phase = 0;
    repeat (2) @(posedge clk);
    #1;
    // Quiet after reset
    for (int i = 0; i < 10; i++) idle(1'b0, 1'b0);
    // Single store round trip
    step(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b1);
    idle(1'b0, 1'b0);
    // Fill, overflow attempt, ordered drain
    for (int i = 1; i <= 5; i++)
      step(1'b1, 32'h100 * i, 32'h0 + i, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) idle(i[0] == 1'b0, i[0] == 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b0);
    // Full buffer with push and response in the same cycle
    for (int i = 1; i <= 4; i++)
      step(1'b1, 32'h500 + 4 * i, 32'hA0 + i, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(1'b1, 1'b0);
    step(1'b1, 32'h600, 32'hBAD, 4'hF, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) idle(i[0] == 1'b0, i[0] == 1'b1);
    // Load hazard against a pending store
    step(1'b1, 32'h0000_2004, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 1'b1, 32'h0000_2006, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b0, 32'h0, 32'h0, 4'h0, i == 1, i == 3, 1'b1, 32'h0000_2006, 1'b0);
    // Youngest of two matches, then reset while awaiting the response
    step(1'b1, 32'h0000_3000, 32'h11, 4'hF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0000_3000, 32'h22, 4'hF, 1'b0, 1'b0, 1'b1, 32'h0000_3000, 1'b0);
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 32'h0000_3000, 1'b0);
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0000_3000, 1'b0);
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0000_3000, 1'b1);
    idle(1'b0, 1'b1);
    // Randomized traffic over a small address pool to force matches
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, ca;
      a  = 32'h0000_1000 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
      ca = 32'h0000_1000 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
      step($urandom_range(0, 2) == 0, a, $urandom,
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1, ca, $urandom_range(0, 199) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
